// File: rtl/nexys_starship_monster_ctrl.sv
// Monster slot controller: four directional slots with lifetime timers,
// shot-based kills, saturating score and an INIT/PLAY/DONE round FSM.
module nexys_starship_monster_ctrl #(
  parameter int LIFETIME = 200_000_000,
  parameter int TIMER_W  = 28
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       spawn_t,
  input  logic       spawn_b,
  input  logic       spawn_l,
  input  logic       spawn_r,
  input  logic       shoot_t,
  input  logic       shoot_b,
  input  logic       shoot_l,
  input  logic       shoot_r,
  output logic       mon_t,
  output logic       mon_b,
  output logic       mon_l,
  output logic       mon_r,
  output logic       hit,
  output logic       miss,
  output logic [7:0] score,
  output logic       q_init,
  output logic       q_play,
  output logic       q_done,
  output logic       game_over
);

  typedef enum logic [2:0] {
    INIT = 3'b001,
    PLAY = 3'b010,
    DONE = 3'b100
  } state_e;

  localparam logic [TIMER_W-1:0] TLOAD = TIMER_W'(LIFETIME - 1);

  state_e             state_q;
  logic [3:0]         alive_q;
  logic [TIMER_W-1:0] timer_q [4];
  logic               hit_q;
  logic               miss_q;
  logic [7:0]         score_q;

  logic [3:0] spawn_v;
  logic [3:0] shoot_v;
  logic [3:0] kill_d;
  logic [3:0] exp_d;
  logic [3:0] miss_v;
  logic [2:0] kills_d;
  logic [8:0] sum_d;
  logic [7:0] score_d;

  assign spawn_v = {spawn_r, spawn_l, spawn_b, spawn_t};
  assign shoot_v = {shoot_r, shoot_l, shoot_b, shoot_t};

  // A shot into an alive slot always kills, even on its last timer cycle
  always_comb begin
    kill_d = alive_q & shoot_v;
    miss_v = ~alive_q & shoot_v & ~spawn_v;
    exp_d  = '0;
    for (int i = 0; i < 4; i++) begin
      exp_d[i] = alive_q[i] & ~shoot_v[i] & (timer_q[i] == '0);
    end
    kills_d = {2'b00, kill_d[0]} + {2'b00, kill_d[1]}
            + {2'b00, kill_d[2]} + {2'b00, kill_d[3]};
    sum_d   = {1'b0, score_q} + {6'd0, kills_d};
    score_d = sum_d[8] ? 8'hFF : sum_d[7:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= INIT;
      alive_q <= '0;
      for (int i = 0; i < 4; i++) timer_q[i] <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      score_q <= '0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      unique case (state_q)
        INIT: begin
          alive_q <= '0;
          if (Start) begin
            state_q <= PLAY;
            score_q <= '0;
          end
        end
        PLAY: begin
          score_q <= score_d;
          hit_q   <= (kills_d != 3'd0);
          miss_q  <= (kills_d == 3'd0) & (|miss_v);
          for (int i = 0; i < 4; i++) begin
            if (alive_q[i]) begin
              if (shoot_v[i]) alive_q[i] <= 1'b0;
              else timer_q[i] <= timer_q[i] - TIMER_W'(1);
            end else if (spawn_v[i]) begin
              alive_q[i] <= 1'b1;
              timer_q[i] <= TLOAD;
            end
          end
          // Expiry overrides every slot update above
          if (|exp_d) begin
            state_q <= DONE;
            alive_q <= '0;
            for (int i = 0; i < 4; i++) timer_q[i] <= '0;
          end
        end
        DONE: begin
          alive_q <= '0;
          if (Ack) state_q <= INIT;
        end
        default: begin
          state_q <= INIT;
          alive_q <= '0;
        end
      endcase
    end
  end

  assign mon_t     = alive_q[0];
  assign mon_b     = alive_q[1];
  assign mon_l     = alive_q[2];
  assign mon_r     = alive_q[3];
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign q_init    = state_q[0];
  assign q_play    = state_q[1];
  assign q_done    = state_q[2];
  assign game_over = state_q[2];

endmodule

// File: tb/tb_nexys_starship_monster_ctrl.sv
// Bench for the monster controller: directed scenarios plus random play,
// compared each cycle against an age-based reference model.
module tb_nexys_starship_monster_ctrl;

  localparam int LIFETIME = 8;
  localparam int TIMER_W  = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Start = 1'b0;
  logic Ack = 1'b0;
  logic spawn_t = 1'b0, spawn_b = 1'b0, spawn_l = 1'b0, spawn_r = 1'b0;
  logic shoot_t = 1'b0, shoot_b = 1'b0, shoot_l = 1'b0, shoot_r = 1'b0;
  logic mon_t, mon_b, mon_l, mon_r, hit, miss;
  logic [7:0] score;
  logic q_init, q_play, q_done, game_over;

  always #5 Clk = ~Clk;

  nexys_starship_monster_ctrl #(
    .LIFETIME(LIFETIME),
    .TIMER_W (TIMER_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .spawn_t(spawn_t), .spawn_b(spawn_b),
    .spawn_l(spawn_l), .spawn_r(spawn_r),
    .shoot_t(shoot_t), .shoot_b(shoot_b),
    .shoot_l(shoot_l), .shoot_r(shoot_r),
    .mon_t(mon_t), .mon_b(mon_b), .mon_l(mon_l), .mon_r(mon_r),
    .hit(hit), .miss(miss), .score(score),
    .q_init(q_init), .q_play(q_play), .q_done(q_done),
    .game_over(game_over)
  );

  int n_checks = 0;
  int n_err = 0;

  // Model: round phase 0/1/2, slot alive flags with birth cycle
  int m_phase;
  bit m_alive [4];
  int m_born [4];
  int m_score;
  bit m_hit, m_miss;
  int cyc;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_score = 0;
    m_hit = 0;
    m_miss = 0;
    for (int i = 0; i < 4; i++) begin
      m_alive[i] = 0;
      m_born[i] = 0;
    end
  endtask

  task automatic model_edge(input bit st, input bit ak,
                            input bit [3:0] sp, input bit [3:0] sh);
    int kills;
    bit shot_empty, expired;
    kills = 0;
    shot_empty = 0;
    expired = 0;
    m_hit = 0;
    m_miss = 0;
    if (m_phase == 0) begin
      if (st) begin
        m_phase = 1;
        m_score = 0;
      end
    end else if (m_phase == 1) begin
      for (int i = 0; i < 4; i++) begin
        if (m_alive[i]) begin
          if (sh[i]) kills++;
          else if (cyc - m_born[i] == LIFETIME) expired = 1;
        end else if (sh[i] && !sp[i]) begin
          shot_empty = 1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (m_alive[i] && sh[i]) m_alive[i] = 0;
        else if (!m_alive[i] && sp[i]) begin
          m_alive[i] = 1;
          m_born[i] = cyc;
        end
      end
      m_score = (m_score + kills > 255) ? 255 : m_score + kills;
      m_hit = (kills > 0);
      m_miss = (kills == 0) && shot_empty;
      if (expired) begin
        m_phase = 2;
        for (int i = 0; i < 4; i++) m_alive[i] = 0;
      end
    end else begin
      if (ak) m_phase = 0;
    end
    cyc++;
  endtask

  task automatic compare_all();
    logic [3:0] em;
    logic [2:0] es;
    em = {m_alive[3], m_alive[2], m_alive[1], m_alive[0]};
    es = 3'b001 << m_phase;
    check("mon", {mon_r, mon_l, mon_b, mon_t}, em);
    check("hit", hit, m_hit);
    check("miss", miss, m_miss);
    check("score", score, m_score);
    check("state", {q_done, q_play, q_init}, es);
    check("game_over", game_over, (m_phase == 2));
  endtask

  task automatic step(input bit st, input bit ak,
                      input bit [3:0] sp, input bit [3:0] sh);
    @(negedge Clk);
    Start = st;
    Ack = ak;
    {spawn_r, spawn_l, spawn_b, spawn_t} = sp;
    {shoot_r, shoot_l, shoot_b, shoot_t} = sh;
    @(posedge Clk);
    model_edge(st, ak, sp, sh);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 4'b0, 4'b0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Start = 0;
    Ack = 0;
    {spawn_r, spawn_l, spawn_b, spawn_t} = '0;
    {shoot_r, shoot_l, shoot_b, shoot_t} = '0;
    Reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    int cnt;
    cyc = 0;
    model_reset();
    #12;
    compare_all();
    @(negedge Clk);
    Reset = 1'b0;

    // Round start
    step(1, 0, 4'b0, 4'b0);
    // Spawn top, shoot 3 cycles later
    step(0, 0, 4'b0001, 4'b0);
    idle(2);
    step(0, 0, 4'b0, 4'b0001);
    check("hit_after_kill", hit, 1);
    check("score_after_kill", score, 1);
    idle(1);

    // Left lives exactly LIFETIME cycles then the round ends
    step(0, 0, 4'b0100, 4'b0);
    cnt = 1;
    for (int k = 0; k < 20 && mon_l; k++) begin
      idle(1);
      if (mon_l) cnt++;
    end
    check("lifetime", cnt, LIFETIME);
    check("done_after_expiry", q_done, 1);
    step(1, 0, 4'b0, 4'b0);
    step(0, 1, 4'b0, 4'b0);
    step(1, 0, 4'b0, 4'b0);

    // Quad kills up to saturation
    for (int k = 0; k < 70; k++) begin
      step(0, 0, 4'b1111, 4'b0);
      step(0, 0, 4'b0, 4'b1111);
    end
    check("score_sat", score, 255);

    // Miss, spawn-beats-shot, Ack ignored in PLAY
    step(0, 1, 4'b0, 4'b1000);
    check("miss_empty", miss, 1);
    step(0, 1, 4'b0010, 4'b0010);
    check("no_miss_spawn", miss, 0);
    step(0, 0, 4'b0, 4'b0010);

    // Shot on the final timer cycle kills without ending the round
    step(0, 0, 4'b0001, 4'b0);
    idle(LIFETIME - 1);
    step(0, 0, 4'b0, 4'b0001);
    check("last_cycle_kill", q_play, 1);

    // Kill top while left expires
    step(0, 0, 4'b0101, 4'b0);
    idle(LIFETIME - 1);
    step(0, 0, 4'b0, 4'b0001);
    check("kill_and_expire", q_done, 1);
    step(0, 1, 4'b0, 4'b0);
    check("ack_to_init", q_init, 1);

    // Reset mid-round
    step(1, 0, 4'b0, 4'b0);
    step(0, 0, 4'b1111, 4'b0);
    do_reset();

    // Random play
    for (int k = 0; k < 4000; k++) begin
      bit [3:0] sp, sh;
      for (int i = 0; i < 4; i++) begin
        sp[i] = ($urandom_range(0, 7) == 0);
        sh[i] = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                sp, sh);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
